// File: rtl/lr35902_dma.sv
// OAM DMA controller (FF46). A write of a source page copies LEN bytes from
// {page, 00..LEN-1} into OAM, one byte per SLOT-clock M-cycle, after a short
// start delay that lets the external bus handover settle.
module lr35902_dma #(
  parameter int LEN       = 160,
  parameter int SLOT      = 4,
  parameter int START_DLY = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_reg_din,
  output logic [7:0]  o_reg_dout,
  input  logic        i_reg_write,
  output logic        o_active,
  output logic        o_drv_ext,
  output logic [15:0] o_adr_rd,
  output logic        o_rd,
  input  logic [7:0]  i_din,
  output logic [7:0]  o_adr_wr,
  output logic        o_wr,
  output logic [7:0]  o_dout
);

  localparam int PW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int CW = $clog2(START_DLY + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_page,  w_page_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [7:0]    r_idx,   w_idx_nxt;
  logic [PW-1:0] r_phase, w_phase_nxt;
  logic [7:0]    r_dout,  w_dout_nxt;

  logic [7:0]    w_src;
  logic          w_xfer;

  // Echo RAM E0..FF mirrors C0..DF, so clear bit 5 for those pages.
  assign w_src  = (r_page[7:5] == 3'b111) ? (r_page & 8'hDF) : r_page;
  assign w_xfer = (r_state == S_XFER);

  assign o_reg_dout = r_page;
  assign o_active   = (r_state != S_IDLE);
  // VRAM (80..9F) is read locally; every other source needs the external bus.
  assign o_drv_ext  = o_active && (w_src[7:5] != 3'b100);
  assign o_adr_rd   = w_xfer ? {w_src, r_idx} : 16'h0000;
  assign o_rd       = w_xfer && (r_phase < PW'(SLOT - 1));
  assign o_wr       = w_xfer && (r_phase == PW'(SLOT - 1));
  assign o_adr_wr   = r_idx;
  assign o_dout     = r_dout;

  // State register; async reset clears everything, so no wr can follow it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_cnt   <= '0;
      r_idx   <= 8'h00;
      r_phase <= '0;
      r_dout  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_page  <= w_page_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // Next-state: start delay, then SLOT phases per byte; a page write always
  // (re)starts the sequence, which also drops an aborted byte's pending wr.
  always_comb begin
    w_state_nxt = r_state;
    w_page_nxt  = r_page;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    w_dout_nxt  = r_dout;
    case (r_state)
      S_IDLE: ;
      S_START: begin
        if (r_cnt == CW'(START_DLY - 1)) begin
          w_state_nxt = S_XFER;
          w_idx_nxt   = 8'h00;
          w_phase_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_XFER: begin
        if (r_phase == PW'(SLOT - 2))
          w_dout_nxt = i_din;
        if (r_phase == PW'(SLOT - 1)) begin
          w_phase_nxt = '0;
          if (r_idx == 8'(LEN - 1)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = 8'h00;
          end else begin
            w_idx_nxt = r_idx + 8'h01;
          end
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_reg_write) begin
      w_page_nxt  = i_reg_din;
      w_state_nxt = S_START;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 8'h00;
      w_phase_nxt = '0;
      w_dout_nxt  = r_dout;
    end
  end

endmodule

// File: doc/lr35902_dma.md
Name: lr35902_dma

Overview:
OAM DMA controller for the video board; register FF46 of the LR35902 PPU address space. A CPU write of a source page starts a 160-byte copy from {page, 8'h00..8'h9F} into OAM. The block sequences the transfer and takes ownership of the external bus when the source is not local VRAM. It drives the top-level dma_active/dma_drvext/adr_dma_rd/adr_dma_wr/rd_dma/wr_dma/data_dma_out nets that are currently tied off.

Parameters:
LEN, 160, bytes per transfer (OAM size)
SLOT, 4, clocks per byte (one M-cycle at 4 MiHz)
START_DLY, 4, clocks from register write to first read slot

Ports:
clk  in  1  gbclk, 4 MiHz; all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
reg_din  in  8  CPU write data
reg_dout  out  8  register read-back
reg_write  in  1  write strobe, already qualified by the FF46 chip select; one clk = one write
active  out  1  transfer in progress (OAM owned by DMA)
drv_ext  out  1  DMA drives the external address bus and n_read
adr_rd  out  16  source address
rd  out  1  read strobe to source (external bus or VRAM)
din  in  8  source data (VRAM dout or external data, muxed in the top)
adr_wr  out  8  OAM destination index
wr  out  1  OAM write strobe
dout  out  8  OAM write data

Behaviour:
- Reset values: page reg 8'h00, reg_dout 8'h00, active 0, drv_ext 0, rd 0, wr 0, adr_rd 0, adr_wr 0, dout 0, state IDLE. Reset dominates a same-cycle reg_write.
- reg_dout is always the last written page. It is readable during a transfer.
- States: IDLE, START, XFER.
- IDLE: reg_write -> latch page, go to START, start delay counter at 0.
- START: START_DLY clocks, then XFER with idx=0, phase=0. active rises on the clock after the write and holds through START.
- XFER: idx 0..LEN-1; 2-bit phase counts 0..SLOT-1 per byte.
  - adr_rd = {src_page, idx} for the whole slot.
  - rd=1 in phases 0-2.
  - din is sampled into dout on the edge that ends phase 2.
  - wr=1 in phase 3, with adr_wr=idx and dout valid.
  - After phase 3 of idx LEN-1, go to IDLE; active, drv_ext, rd and wr are 0 on the next clock.
- Total transfer: active high for exactly START_DLY + LEN*SLOT = 644 clocks per uninterrupted transfer.
- Source page mapping:
  - pages 8'hE0..8'hFF have bit 5 cleared (echo RAM: E3 -> C3);
  - all other pages are used as written.
- drv_ext = active && (src_page[7:5] != 3'b100). VRAM pages 80..9F stay local, so the external bus is not taken. drv_ext is also high during START so the bus handover settles before the first rd.
- Restart: reg_write while in START or XFER reloads the page and returns to START with the counters cleared. The aborted byte's wr is suppressed if its phase 3 has not yet occurred. active stays high with no gap; drv_ext is recomputed from the new page.
- Mid-transfer reset: everything returns to reset values immediately. No partial wr is issued after reset asserts.
- adr_wr is 8 bits wide; idx never exceeds LEN-1, so there is no wrap.
- rd and wr are never high in the same cycle.

Test Plan:
- Basic transfer: write 8'hC1 at t0.
  - active goes high at t0+1 for 644 clocks.
  - 160 wr pulses with adr_wr 0..159; adr_rd runs C100..C19F.
  - dout equals the din pattern presented in phase 2 of each slot; drv_ext=1 throughout.
- VRAM source: write 8'h85 -> adr_rd runs 8500..859F, drv_ext=0 while active=1, 160 wr pulses.
- Echo mapping: write 8'hE3 -> adr_rd=C300 on the first slot, reg_dout reads 8'hE3.
- Restart: write 8'hC0, then at byte 50 phase 1 write 8'hD0.
  - No wr occurs for idx 50 of the old transfer.
  - After 4 clocks, adr_rd=D000 and adr_wr=0.
  - active never drops; the final wr is for D09F.
- Reset mid-transfer: assert reset at byte 80 phase 3 (asynchronously, between edges).
  - All outputs go to 0 at once; reg_dout=00.
  - A subsequent write 8'hC2 runs a full 644-clock transfer.
- Simultaneous reset and reg_write: state remains IDLE and reg_dout=00.
